alu_share_arbiter: RTL and testbench

- Shares one 16-bit combinational ALU between two requesters, port 0 and port 1.
- Each port issues a command (operands plus 4-bit opcode) over a valid/ready handshake and receives its result over a separate valid/ready response channel.
- The block arbitrates round-robin, registers operands, sequences the ALU through a 3-state FSM, and routes the result back to the winning port.
- It sits between the instruction-issue logic and the shared ALU.

---
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit combinational ALU between two requesters.
// Each command runs IDLE -> EXEC -> RESP, and the result returns on the winner's response channel.
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Shift amounts use the full b operand, so any b of DATA_W or more clears the result.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = (b >= DATA_W'(DATA_W)) ? '0 : (a << b);
            4'b0110: r = (b >= DATA_W'(DATA_W)) ? '0 : (a >> b);
            4'b0111: r = ~a;
            4'b1000: r = (a < b) ? DATA_W'(1) : '0;
            4'b1001: r = (a > b) ? DATA_W'(1) : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        req_ready_s;
    logic              winner_s;
    logic              rsp_fire_s;

    // Next-state, arbitration and datapath capture.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        req_ready_s  = 2'b00;
        rsp_fire_s   = grant_id_q ? rsp1_ready : rsp0_ready;

        // On a tie the port that was not served last wins.
        if (req0_valid && req1_valid) begin
            winner_s = ~last_grant_q;
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req_ready_s = winner_s ? 2'b10 : 2'b01;
                    a_d         = winner_s ? req1_a  : req0_a;
                    b_d         = winner_s ? req1_b  : req0_b;
                    op_d        = winner_s ? req1_op : req0_op;
                    grant_id_d  = winner_s;
                    state_d     = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_eval(a_q, b_q, op_q);
                rsp_valid_d = grant_id_q ? 2'b10 : 2'b01;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    rsp_valid_d  = 2'b00;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req0_ready = req_ready_s[0];
    assign req1_ready = req_ready_s[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model and a round-robin grant model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [15:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int last_g = 1;

    alu_share_arbiter #(.DATA_W(16), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input int unsigned a, input int unsigned b, input int unsigned op);
        int unsigned r;
        case (op)
            0:       r = (a + b) % 65536;
            1:       r = (a + 65536 - b) % 65536;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (b >= 16) ? 0 : (a * (32'd1 << b)) % 65536;
            6:       r = (b >= 16) ? 0 : a / (32'd1 << b);
            7:       r = 65535 - a;
            8:       r = (a < b) ? 1 : 0;
            9:       r = (a > b) ? 1 : 0;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered one time unit after an edge with the block in IDLE and the requests driven.
    task automatic serve(input bit keep);
        int w;
        logic [15:0] exp;
        if (req0_valid && req1_valid) w = 1 - last_g;
        else if (req1_valid)          w = 1;
        else                          w = 0;
        exp = (w == 1) ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
        #1;
        chk("req0_ready_accept", req0_ready, w == 0);
        chk("req1_ready_accept", req1_ready, w == 1);
        step();
        if (!keep) begin
            if (w == 1) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        chk("exec_busy", busy, 1);
        chk("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("exec_req_ready", {req1_ready, req0_ready}, 0);
        step();
        chk("resp_rsp0_valid", rsp0_valid, w == 0);
        chk("resp_rsp1_valid", rsp1_valid, w == 1);
        chk("resp_data", rsp_data, exp);
        chk("resp_req_ready", {req1_ready, req0_ready}, 0);
        step();
        chk("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        last_g = w;
    endtask

    task automatic issue(input int p, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        if (p == 1) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else        begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        last_g = 1;
        step();
    endtask

    initial begin
        logic [15:0] held;
        {req0_valid, req1_valid} = 2'b00;
        {req0_a, req0_b, req1_a, req1_b} = '0;
        {req0_op, req1_op} = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_req_ready", {req1_ready, req0_ready}, 0);

        // single request on port 0
        issue(0, 16'h0005, 16'h0003, 4'b0000);
        serve(1'b0);
        chk("single_busy_after", busy, 0);

        // simultaneous requests after reset: 0 then 1, then alternate 0,1,0
        do_reset();
        issue(0, 16'h000A, 16'h0003, 4'b0001);
        issue(1, 16'hF0F0, 16'h0FF0, 4'b0010);
        for (int k = 0; k < 5; k++) serve(1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // backpressure on port 1
        rsp1_ready = 1'b0;
        issue(1, 16'h1234, 16'h0004, 4'b0101);
        step();
        req1_valid = 1'b0;
        step();
        held = ref_alu(16'h1234, 16'h0004, 4'b0101);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_rsp0_valid", rsp0_valid, 0);
            chk("bp_data", rsp_data, held);
            chk("bp_req_ready", {req1_ready, req0_ready}, 0);
            chk("bp_busy", busy, 1);
            step();
        end
        rsp1_ready = 1'b1;
        step();
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", rsp1_valid, 0);
        last_g = 1;

        // boundary arithmetic
        issue(0, 16'hFFFF, 16'h0001, 4'b0000); serve(1'b0);
        issue(1, 16'h0000, 16'h0001, 4'b0001); serve(1'b0);
        issue(0, 16'h0001, 16'h0014, 4'b0101); serve(1'b0);
        issue(1, 16'hABCD, 16'h1234, 4'b1100); serve(1'b0);
        issue(0, 16'h0003, 16'h0007, 4'b1000); serve(1'b0);
        issue(1, 16'h8001, 16'h0010, 4'b0110); serve(1'b0);

        // reset while in EXEC
        issue(0, 16'h1111, 16'h2222, 4'b0000);
        step();
        req0_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", {rsp1_valid, rsp0_valid}, 0);
        step();
        rst_n = 1'b1;
        last_g = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_rsp", {rsp1_valid, rsp0_valid, busy}, 0);
        end
        issue(1, 16'h0F00, 16'h00F0, 4'b0011);
        serve(1'b0);

        // request withdrawal while port 0 response is stalled
        rsp0_ready = 1'b0;
        issue(0, 16'h0009, 16'h0002, 4'b1001);
        step();
        req0_valid = 1'b0;
        step();
        req1_valid = 1'b1;
        #1;
        chk("wd_req1_ready", req1_ready, 0);
        step();
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        step();
        last_g = 0;
        for (int k = 0; k < 3; k++) begin
            chk("wd_idle", {rsp1_valid, rsp0_valid, busy}, 0);
            step();
        end

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic [3:0] op;
            sel = $urandom_range(0, 2);
            if (sel != 1) begin
                op = 4'($urandom_range(0, 15));
                issue(0, 16'($urandom), (op == 4'd5 || op == 4'd6) ? 16'($urandom_range(0, 20)) : 16'($urandom), op);
            end
            if (sel != 0) begin
                op = 4'($urandom_range(0, 15));
                issue(1, 16'($urandom), (op == 4'd5 || op == 4'd6) ? 16'($urandom_range(0, 20)) : 16'($urandom), op);
            end
            serve(1'b0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
